// File: rtl/demux12_4bit_buf.sv
// -----------------------------------------------------------------------------
// demux12_4bit_buf
//
// Registered 1-to-2 demultiplexer with a small FIFO on each output channel.
// One valid/ready input stream carries a word plus a select bit. The select
// bit steers the word into the FIFO of channel 0 or channel 1. Each channel
// drains independently, so a stalled consumer only holds back words that are
// headed for its own channel.
//
// Parameters
//   WIDTH : data word width in bits
//   DEPTH : FIFO entries per channel (power of two, >= 2)
//   CNT_W : width of the per-channel accepted-word counters (wrap, no saturation)
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset; clears FIFOs, pointers, counters
//   in_data    : word to route
//   in_sel     : destination channel (0 or 1)
//   in_valid   : in_data/in_sel are valid
//   in_ready   : destination FIFO is not full (combinational from in_sel)
//   out0_data  : head word of channel 0 FIFO (driven from storage only)
//   out0_valid : channel 0 FIFO not empty
//   out0_ready : channel 0 consumer takes the head word
//   out1_data  : head word of channel 1 FIFO
//   out1_valid : channel 1 FIFO not empty
//   out1_ready : channel 1 consumer takes the head word
//   cnt0       : words accepted into channel 0 (modulo 2^CNT_W)
//   cnt1       : words accepted into channel 1 (modulo 2^CNT_W)
// -----------------------------------------------------------------------------
module demux12_4bit_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int NCH   = 2;

    // Per-channel state, indexed by channel number.
    logic [WIDTH-1:0] mem_q    [NCH][DEPTH];
    logic [WIDTH-1:0] mem_d    [NCH][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NCH];
    logic [PTR_W-1:0] wr_ptr_d [NCH];
    logic [PTR_W-1:0] rd_ptr_q [NCH];
    logic [PTR_W-1:0] rd_ptr_d [NCH];
    logic [OCC_W-1:0] occ_q    [NCH];
    logic [OCC_W-1:0] occ_d    [NCH];
    logic [CNT_W-1:0] cnt_q    [NCH];
    logic [CNT_W-1:0] cnt_d    [NCH];

    logic [NCH-1:0] full;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;

    // -------------------------------------------------------------------------
    // Handshake decode.
    // Full is judged on the registered occupancy only, so a pop in the same
    // cycle never opens a slot for the incoming word: no pass-through path.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a value before any branch;
        // combinational blocks use blocking '=' so later lines see earlier results.
        full      = '0;
        out_valid = '0;
        push      = '0;
        pop       = '0;
        out_ready = {out1_ready, out0_ready};

        for (int ch = 0; ch < NCH; ch++) begin
            full[ch]      = (occ_q[ch] == OCC_W'(DEPTH));
            out_valid[ch] = (occ_q[ch] != '0);
        end

        in_ready = ~full[in_sel];

        for (int ch = 0; ch < NCH; ch++) begin
            // in_sel only matters when in_valid is high.
            push[ch] = in_valid & in_ready & (in_sel == 1'(ch));
            pop[ch]  = out_valid[ch] & out_ready[ch];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: storage write, pointer advance, occupancy and counters.
    // Pointers are PTR_W bits wide, so with DEPTH a power of two the +1
    // wraps modulo DEPTH on its own.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;

        for (int ch = 0; ch < NCH; ch++) begin
            if (push[ch]) begin
                mem_d[ch][wr_ptr_q[ch]] = in_data;
                wr_ptr_d[ch]            = wr_ptr_q[ch] + PTR_W'(1);
                cnt_d[ch]               = cnt_q[ch] + CNT_W'(1);
            end
            if (pop[ch]) begin
                rd_ptr_d[ch] = rd_ptr_q[ch] + PTR_W'(1);
            end
            // Push and pop together leave occupancy unchanged.
            occ_d[ch] = occ_q[ch] + OCC_W'(push[ch]) - OCC_W'(pop[ch]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                // NOTE: storage is cleared too, so the head word reads 0 after
                // reset and no stale word survives a mid-transfer reset.
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[ch][i] <= '0;
                end
                wr_ptr_q[ch] <= '0;
                rd_ptr_q[ch] <= '0;
                occ_q[ch]    <= '0;
                cnt_q[ch]    <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: head word comes straight from storage, never from in_data.
    // -------------------------------------------------------------------------
    assign out0_data  = mem_q[0][rd_ptr_q[0]];
    assign out1_data  = mem_q[1][rd_ptr_q[1]];
    assign out0_valid = out_valid[0];
    assign out1_valid = out_valid[1];
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux12_4bit_buf.sv
// -----------------------------------------------------------------------------
// tb_demux12_4bit_buf
//
// Directed bench for demux12_4bit_buf. Main instance uses default parameters;
// a second instance with CNT_W=3 exercises counter wrap.
// -----------------------------------------------------------------------------
module tb_demux12_4bit_buf;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;

    // Main DUT signals
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;

    // Small-counter DUT signals
    logic [WIDTH-1:0] b_in_data;
    logic             b_in_sel;
    logic             b_in_valid;
    logic             b_in_ready;
    logic [WIDTH-1:0] b_out0_data;
    logic             b_out0_valid;
    logic             b_out0_ready;
    logic [WIDTH-1:0] b_out1_data;
    logic             b_out1_valid;
    logic             b_out1_ready;
    logic [2:0]       b_cnt0;
    logic [2:0]       b_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    demux12_4bit_buf #(.WIDTH(WIDTH), .DEPTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    demux12_4bit_buf #(.WIDTH(WIDTH), .DEPTH(2), .CNT_W(3)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (b_in_data),
        .in_sel     (b_in_sel),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .out0_data  (b_out0_data),
        .out0_valid (b_out0_valid),
        .out0_ready (b_out0_ready),
        .out1_data  (b_out1_data),
        .out1_valid (b_out1_valid),
        .out1_ready (b_out1_ready),
        .cnt0       (b_cnt0),
        .cnt1       (b_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        rst_n      = 1'b0;
        #3;
        rst_n      = 1'b1;
        tick();
    endtask

    // Safety net: the directed sequence is a few hundred cycles at most.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int next_push;
        int next_pop;
        logic will_push;
        logic will_pop;

        rst_n        = 1'b0;
        in_data      = '0;
        in_sel       = 1'b0;
        in_valid     = 1'b0;
        out0_ready   = 1'b0;
        out1_ready   = 1'b0;
        b_in_data    = '0;
        b_in_sel     = 1'b0;
        b_in_valid   = 1'b0;
        b_out0_ready = 1'b0;
        b_out1_ready = 1'b0;

        // ---------------- Reset state ----------------
        #12;
        check("rst_out0_valid", 32'(out0_valid), 0);
        check("rst_out1_valid", 32'(out1_valid), 0);
        check("rst_out0_data",  32'(out0_data),  0);
        check("rst_out1_data",  32'(out1_data),  0);
        check("rst_cnt0",       32'(cnt0),       0);
        check("rst_cnt1",       32'(cnt1),       0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        tick();

        // ---------------- 1: reset then route ----------------
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
        #1;
        check("t1_in_ready_a", 32'(in_ready), 1);
        tick();
        check("t1_out0_valid", 32'(out0_valid), 1);
        check("t1_out0_data",  32'(out0_data),  'h3);
        in_sel = 1'b1; in_data = 4'hA;
        #1;
        check("t1_in_ready_b", 32'(in_ready), 1);
        tick();
        check("t1_out1_valid", 32'(out1_valid), 1);
        check("t1_out1_data",  32'(out1_data),  'hA);
        check("t1_out0_drained", 32'(out0_valid), 0);
        in_valid = 1'b0;
        tick();
        check("t1_cnt0", 32'(cnt0), 1);
        check("t1_cnt1", 32'(cnt1), 1);
        check("t1_out1_drained", 32'(out1_valid), 0);

        // ---------------- 2: channel 0 fill and stall ----------------
        do_reset();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
        #1;
        check("t2_ready_push1", 32'(in_ready), 1);
        tick();
        in_data = 4'h2;
        #1;
        check("t2_ready_push2", 32'(in_ready), 1);
        tick();
        in_data = 4'h4;
        #1;
        check("t2_ready_full", 32'(in_ready), 0);
        tick();
        check("t2_cnt0_stalled", 32'(cnt0), 2);
        check("t2_head_1", 32'(out0_data), 'h1);
        // Other channel still accepts while channel 0 is full.
        in_sel = 1'b1; in_data = 4'h7;
        #1;
        check("t2_ready_ch1", 32'(in_ready), 1);
        tick();
        check("t2_out1_valid", 32'(out1_valid), 1);
        check("t2_out1_data",  32'(out1_data),  'h7);
        check("t2_cnt1",       32'(cnt1),       1);
        // Drain channel 0; the pending 0x4 waits for a free slot.
        in_sel = 1'b0; in_data = 4'h4; out0_ready = 1'b1;
        #1;
        check("t2_no_passthru", 32'(in_ready), 0);
        tick();
        check("t2_head_2", 32'(out0_data), 'h2);
        #1;
        check("t2_ready_after_pop", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t2_head_4", 32'(out0_data), 'h4);
        check("t2_cnt0",   32'(cnt0),      3);
        tick();
        check("t2_out0_empty", 32'(out0_valid), 0);

        // ---------------- 3: full plus simultaneous pop ----------------
        do_reset();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h5;
        tick();
        in_data = 4'h6;
        tick();
        in_data = 4'h8; out1_ready = 1'b1;
        #1;
        check("t3_refused", 32'(in_ready), 0);
        check("t3_head_5",  32'(out1_data), 'h5);
        tick();
        check("t3_head_6",  32'(out1_data), 'h6);
        check("t3_cnt1_hold", 32'(cnt1), 2);
        #1;
        check("t3_accept_next", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t3_head_8",  32'(out1_data), 'h8);
        check("t3_cnt1",    32'(cnt1), 3);
        tick();
        check("t3_out1_empty", 32'(out1_valid), 0);

        // ---------------- 4: wrap-around stream ----------------
        do_reset();
        in_sel    = 1'b0;
        next_push = 0;
        next_pop  = 0;
        for (int cyc = 0; cyc < 80 && next_pop < 10; cyc++) begin
            out0_ready = cyc[0];
            in_valid   = (next_push < 10);
            in_data    = 4'(next_push);
            #1;
            will_push = in_valid & in_ready;
            will_pop  = out0_valid & out0_ready;
            if (will_pop) begin
                check($sformatf("t4_word%0d", next_pop), 32'(out0_data), 32'(next_pop));
            end
            tick();
            if (will_push) next_push++;
            if (will_pop)  next_pop++;
        end
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        check("t4_words_out", 32'(next_pop), 10);
        check("t4_cnt0",      32'(cnt0),     10);
        check("t4_empty",     32'(out0_valid), 0);

        // ---------------- 5: counter wrap with CNT_W=3 ----------------
        do_reset();
        b_out1_ready = 1'b1;
        b_in_valid   = 1'b1;
        b_in_sel     = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b_in_data = 4'(i);
            if (i == 8) check("t5_cnt1_at8", 32'(b_cnt1), 0);
            tick();
        end
        b_in_valid = 1'b0;
        check("t5_cnt1_wrap", 32'(b_cnt1), 1);
        check("t5_cnt0",      32'(b_cnt0), 0);

        // ---------------- 6: mid-operation asynchronous reset ----------------
        do_reset();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h9;
        tick();
        in_sel = 1'b1; in_data = 4'hC;
        tick();
        in_valid = 1'b0;
        check("t6_pre_out0_valid", 32'(out0_valid), 1);
        check("t6_pre_out1_valid", 32'(out1_valid), 1);
        #2;  // between clock edges
        rst_n = 1'b0;
        #1;
        check("t6_out0_valid", 32'(out0_valid), 0);
        check("t6_out1_valid", 32'(out1_valid), 0);
        check("t6_out0_data",  32'(out0_data),  0);
        check("t6_cnt0",       32'(cnt0),       0);
        check("t6_cnt1",       32'(cnt1),       0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_in_ready", 32'(in_ready), 1);
        tick();
        check("t6_still_empty", 32'(out1_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux12_4bit_buf.md
Name: demux12_4bit_buf

Overview:
- Registered 1-to-2 demultiplexer, the inverse of the 4-bit 2:1 mux in the ALU datapath.
- Takes one valid/ready input stream, with a per-word select bit, and steers each word to one of two output channels.
- Each output channel has its own small FIFO, so a stalled channel does not corrupt data.
- Used to split ALU result words between two consumers, for example the register writeback path and the flag/debug path.

Parameters:
- WIDTH, 4: data word width in bits.
- DEPTH, 2: FIFO entries per output channel. Must be a power of two and at least 2.
- CNT_W, 8: width of the per-channel accepted-word counters.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_data, input, WIDTH: word to route.
- in_sel, input, 1: destination. 0 selects channel 0, 1 selects channel 1.
- in_valid, input, 1: in_data and in_sel are valid.
- in_ready, output, 1: the block can accept the word on this cycle.
- out0_data, output, WIDTH: head word of the channel 0 FIFO.
- out0_valid, output, 1: channel 0 FIFO is not empty.
- out0_ready, input, 1: channel 0 consumer accepts the head word.
- out1_data, output, WIDTH: head word of the channel 1 FIFO.
- out1_valid, output, 1: channel 1 FIFO is not empty.
- out1_ready, input, 1: channel 1 consumer accepts the head word.
- cnt0, output, CNT_W: number of words accepted into channel 0.
- cnt1, output, CNT_W: number of words accepted into channel 1.

Behaviour:
- Reset (asynchronous on rst_n low):
  - All read/write pointers and occupancy counts go to 0.
  - All FIFO storage goes to 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0; cnt0 = cnt1 = 0.
  - in_ready = 1 once rst_n is high, because both FIFOs are empty.
  - Reset asserted mid-transfer discards every queued word. No partial state survives.
- Input acceptance:
  - in_ready is combinational: in_ready = NOT full[in_sel].
  - The source holds in_data and in_sel stable while in_valid=1 and in_ready=0.
  - A push occurs on a rising edge where in_valid=1 and in_ready=1. The word is written to FIFO[in_sel] and cnt[in_sel] increments by 1.
- Output side:
  - outN_valid = (occupancyN != 0).
  - outN_data = the entry at rdptrN. It is driven from storage only; there is no combinational path from in_data.
  - A pop occurs on a rising edge where outN_valid=1 and outN_ready=1. rdptrN advances.
  - outN_ready with outN_valid=0 is a no-op.
- Latency: a word accepted at edge k appears on outN_data with outN_valid=1 immediately after edge k, provided the channel was empty. Minimum latency is 1 cycle.
- Ordering: strict FIFO order within each channel. There is no ordering relation between the two channels.
- Independence: a full or stalled channel blocks only words destined for it. in_ready stays high for a word destined for the other, non-full channel.
- Simultaneous push and pop:
  - Same channel, not full: both happen and occupancy is unchanged.
  - Same channel, full: in_ready=0 even if a pop occurs that cycle. There is no pass-through. The push waits one cycle.
  - Pop on one channel and push on the other in the same cycle: both happen independently.
- Pointer rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is a separate counter, log2(DEPTH)+1 bits, ranging 0..DEPTH. Full means occupancy == DEPTH.
- Counters: cnt0 and cnt1 wrap modulo 2^CNT_W with no saturation. They count accepted words only, never pops.
- Illegal input: in_sel is ignored when in_valid=0. It may toggle freely while in_valid=0.

Test Plan:
1. Reset then route: release rst_n, then push 0x3 with sel=0 and 0xA with sel=1 on consecutive cycles, outN_ready=1.
   - Required: in_ready=1 throughout.
   - out0_data=0x3 with out0_valid=1 one edge after the first push; out1_data=0xA similarly.
   - cnt0=1, cnt1=1.
2. Channel 0 fill and stall: out0_ready=0, push 0x1, 0x2, then 0x4 on sel=0.
   - Required: in_ready drops to 0 after 2 pushes while in_sel=0.
   - A sel=1 word 0x7 is still accepted.
   - Raise out0_ready: words drain as 0x1, 0x2, then 0x4 is accepted; cnt0=3.
3. Full plus simultaneous pop: channel 1 holds 2 words, out1_ready=1, push sel=1.
   - Required: push is refused that cycle, accepted on the next cycle; order is preserved.
4. Wrap-around: stream 10 words 0x0..0x9 on sel=0 with out0_ready toggling every cycle.
   - Required: outputs are exactly 0x0..0x9 in order with no loss or duplication; cnt0=10.
5. Counter wrap with CNT_W=3: push 9 words to channel 1.
   - Required: cnt1 reads 1.
6. Mid-operation reset: both FIFOs hold 1 word, then pulse rst_n low asynchronously (not on a clock edge).
   - Required: out0_valid, out1_valid, cnt0 and cnt1 go to 0 immediately, and in_ready=1 after release.
